// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared types and constants for the buffered UART transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    localparam logic UART_IDLE_LVL  = 1'b1;
    localparam logic UART_START_LVL = 1'b0;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_fifo
// Description : Synchronous write FIFO with registered full/empty flags.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_data,
    output logic              o_full,
    output logic              o_empty
);

    localparam int c_ptr_w = (clog2(FIFO_DEPTH) < 1) ? 1 : clog2(FIFO_DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(FIFO_DEPTH);

    logic [DATA_W-1:0]  r_mem [FIFO_DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic [c_cnt_w-1:0] w_count_nxt;
    logic               r_full;
    logic               r_empty;
    logic               w_do_push;
    logic               w_do_pop;

    // A full FIFO drops the write even when a pop frees a slot this cycle.
    assign w_do_push = i_push & ~r_full;
    assign w_do_pop  = i_pop & ~r_empty;

    always_comb begin
        w_count_nxt = r_count;
        case ({w_do_push, w_do_pop})
            2'b10:   w_count_nxt = r_count + 1'b1;
            2'b01:   w_count_nxt = r_count - 1'b1;
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == c_depth);
            r_empty <= (w_count_nxt == '0);
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_full  = r_full;
    assign o_empty = r_empty;

endmodule
`default_nettype wire

// File: rtl/uart_tx_buffered.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_buffered
// Description : FIFO-buffered UART transmitter driven by a 16x oversample tick.
//               Define UART_TX_PARITY_EN to append an even parity bit (8E1).
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int OVERSAMPLE = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_b_tick,
    input  logic              i_wr_en,
    input  logic [DATA_W-1:0] i_wr_data,
    output logic              o_full,
    output logic              o_empty,
    output logic              o_tx,
    output logic              o_tx_busy,
    output logic              o_tx_done
);

    localparam int c_tick_w = (clog2(OVERSAMPLE) < 1) ? 1 : clog2(OVERSAMPLE);
    localparam int c_bit_w  = (clog2(DATA_W) < 1) ? 1 : clog2(DATA_W);
    localparam logic [c_tick_w-1:0] c_tick_last = c_tick_w'(OVERSAMPLE - 1);
    localparam logic [c_bit_w-1:0]  c_bit_last  = c_bit_w'(DATA_W - 1);

    tx_state_t           r_state;
    logic [c_tick_w-1:0] r_tick_cnt;
    logic [c_bit_w-1:0]  r_bit_cnt;
    logic [DATA_W-1:0]   r_shift;
    logic                r_tx;
    logic                r_busy;
    logic                r_done;
`ifdef UART_TX_PARITY_EN
    logic                r_parity;
`endif

    logic [DATA_W-1:0]   w_fifo_data;
    logic                w_fifo_full;
    logic                w_fifo_empty;
    logic                w_bit_end;
    logic                w_pop;

    uart_tx_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (i_wr_en),
        .i_data  (i_wr_data),
        .i_pop   (w_pop),
        .o_data  (w_fifo_data),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    assign w_bit_end = i_b_tick && (r_tick_cnt == c_tick_last);
    // Pop from IDLE, or at the end of STOP so the next start bit follows with no gap.
    assign w_pop = ~w_fifo_empty &&
                   ((r_state == IDLE) || ((r_state == STOP) && w_bit_end));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_tx       <= UART_IDLE_LVL;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_parity   <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            if ((r_state != IDLE) && i_b_tick) begin
                r_tick_cnt <= w_bit_end ? '0 : r_tick_cnt + 1'b1;
            end

            case (r_state)
                IDLE: begin
                    if (w_pop) begin
                        r_shift <= w_fifo_data;
                        r_state <= START;
                        r_tx    <= UART_START_LVL;
                        r_busy  <= 1'b1;
`ifdef UART_TX_PARITY_EN
                        r_parity <= ^w_fifo_data;
`endif
                    end
                end

                START: begin
                    if (w_bit_end) begin
                        r_state   <= DATA;
                        r_tx      <= r_shift[0];
                        r_bit_cnt <= '0;
                    end
                end

                DATA: begin
                    if (w_bit_end) begin
                        if (r_bit_cnt == c_bit_last) begin
`ifdef UART_TX_PARITY_EN
                            r_state <= PARITY;
                            r_tx    <= r_parity;
`else
                            r_state <= STOP;
                            r_tx    <= UART_IDLE_LVL;
`endif
                        end else begin
                            r_shift   <= r_shift >> 1;
                            r_tx      <= r_shift[1];
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                end

`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (w_bit_end) begin
                        r_state <= STOP;
                        r_tx    <= UART_IDLE_LVL;
                    end
                end
`endif

                STOP: begin
                    if (w_bit_end) begin
                        r_done <= 1'b1;
                        if (w_pop) begin
                            r_shift <= w_fifo_data;
                            r_state <= START;
                            r_tx    <= UART_START_LVL;
`ifdef UART_TX_PARITY_EN
                            r_parity <= ^w_fifo_data;
`endif
                        end else begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                end

                default: begin
                    r_state <= IDLE;
                    r_tx    <= UART_IDLE_LVL;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_full    = w_fifo_full;
    assign o_empty   = w_fifo_empty;
    assign o_tx      = r_tx;
    assign o_tx_busy = r_busy;
    assign o_tx_done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_buffered.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_buffered
// Description : Scoreboard bench: queued expected bytes vs frames decoded from tx.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_buffered;

    localparam int OS       = 16;
    localparam int TICK_DIV = 4;
    localparam int DEPTH    = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       b_tick = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       full, empty, tx, busy, done;

    uart_tx_buffered #(.DATA_W(8), .FIFO_DEPTH(DEPTH), .OVERSAMPLE(OS)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_b_tick  (b_tick),
        .i_wr_en   (wr_en),
        .i_wr_data (wr_data),
        .o_full    (full),
        .o_empty   (empty),
        .o_tx      (tx),
        .o_tx_busy (busy),
        .o_tx_done (done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    logic [7:0] exp_q[$];
    int n_accepted = 0;
    bit tick_en = 1'b1;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Line image of one frame, LSB (start bit) first.
    function automatic logic [10:0] frame_of(input logic [7:0] b);
        logic [10:0] f;
        f = '0;
        f[8:1] = b;
`ifdef UART_TX_PARITY_EN
        f[9]  = ^b;
        f[10] = 1'b1;
`else
        f[9]  = 1'b1;
`endif
        return f;
    endfunction

    // Tick source: one pulse every TICK_DIV clocks, suppressible.
    initial begin
        int tdiv;
        tdiv = 0;
        forever begin
            @(posedge clk);
            #1;
            tdiv   = (tdiv + 1) % TICK_DIV;
            b_tick = tick_en && (tdiv == 0);
        end
    end

    // Monitor: decode frames by counting ticks from the start-bit edge.
    bit          mon_active = 1'b0;
    int          mon_tcnt = 0;
    int          mon_k = 0;
    logic [10:0] mon_bits = '0;
    int          mon_started = 0, mon_done = 0, mon_chained = 0;

    task automatic mon_start();
        mon_active = 1'b1;
        mon_tcnt   = 0;
        mon_k      = 0;
        mon_bits   = '0;
        mon_started++;
        check("busy_at_start", busy, 1);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            mon_active = 1'b0;
        end else begin
            if (mon_active && done) begin
                check("frame_len_ticks", mon_tcnt, OS * FRAME_BITS);
                mon_done++;
                if (tx == 1'b0) begin
                    mon_chained++;
                    mon_start();
                end else begin
                    check("busy_clear_with_done", busy, 0);
                    mon_active = 1'b0;
                end
            end else if (!mon_active && tx == 1'b0) begin
                mon_start();
            end
            if (mon_active && b_tick) begin
                mon_tcnt++;
                if ((mon_tcnt % OS) == OS / 2 && mon_k < FRAME_BITS) begin
                    mon_bits[mon_k] = tx;
                    mon_k++;
                    if (mon_k == FRAME_BITS) begin
                        check("frame_expected", exp_q.size() > 0, 1);
                        if (exp_q.size() > 0) check("frame_bits", mon_bits, frame_of(exp_q.pop_front()));
                    end
                end
                if (mon_tcnt > OS * (FRAME_BITS + 1)) begin
                    check("frame_done_timeout", mon_tcnt, OS * FRAME_BITS);
                    mon_active = 1'b0;
                end
            end
        end
    end

    task automatic write_byte(input logic [7:0] b);
        @(posedge clk);
        #1;
        wr_en   = 1'b1;
        wr_data = b;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int limit);
        int n;
        n = 0;
        while (!(exp_q.size() == 0 && !mon_active && !busy && empty) && n < limit) begin
            @(posedge clk);
            n++;
        end
        #1;
        check(name, (exp_q.size() == 0 && !mon_active && !busy && empty), 1);
    endtask

    initial begin
        int d0, c0, s0, n;
        logic [7:0] b;
        logic [7:0] burst [6];

        repeat (3) @(posedge clk);
        #1;
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        rst = 1'b0;
        repeat (5) @(posedge clk);

        // Single byte with latency checks.
        d0 = mon_done;
        @(posedge clk);
        #1;
        wr_en = 1'b1; wr_data = 8'h72;
        exp_q.push_back(8'h72); n_accepted++;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        check("lat_empty_low", empty, 0);
        check("lat_tx_before_pop", tx, 1);
        @(posedge clk);
        #1;
        check("lat_tx_start", tx, 0);
        check("lat_busy", busy, 1);
        wait_idle("single_drain", 2000);
        check("single_done_count", mon_done - d0, 1);

        // Back-to-back r, c, m.
        d0 = mon_done; c0 = mon_chained;
        burst[0] = 8'h72; burst[1] = 8'h63; burst[2] = 8'h6D;
        @(posedge clk);
        #1;
        wr_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wr_data = burst[i];
            exp_q.push_back(burst[i]); n_accepted++;
            @(posedge clk);
            #1;
        end
        wr_en = 1'b0;
        wait_idle("b2b_drain", 4000);
        check("b2b_done_count", mon_done - d0, 3);
        check("b2b_gapless", mon_chained - c0, 2);
        check("b2b_empty", empty, 1);

        // Overflow: 6 consecutive writes into an idle, empty block.
        d0 = mon_done;
        for (int i = 0; i < 6; i++) burst[i] = 8'($urandom);
        @(posedge clk);
        #1;
        wr_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            wr_data = burst[i];
            if (i < 5) begin
                exp_q.push_back(burst[i]); n_accepted++;
            end
            @(posedge clk);
            #1;
        end
        wr_en = 1'b0;
        check("ovf_full", full, 1);
        wait_idle("ovf_drain", 6000);
        check("ovf_done_count", mon_done - d0, 5);

        // Reset in the middle of DATA bit 3.
        write_byte(8'hA5);
        exp_q.push_back(8'hA5); n_accepted++;
        n = 0;
        while (!(mon_active && mon_tcnt >= OS * 4 + OS / 2) && n < 2000) begin
            @(posedge clk);
            n++;
        end
        check("rst_mid_reached", (mon_active && mon_tcnt >= OS * 4 + OS / 2), 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_mid_tx", tx, 1);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_empty", empty, 1);
        rst = 1'b0;
        exp_q.delete();
        s0 = mon_started;
        repeat (1500) @(posedge clk);
        #1;
        check("rst_mid_no_frames", mon_started - s0, 0);
        check("rst_mid_tx_idle", tx, 1);

        // Tick gating: frame must freeze in START and resume cleanly.
        tick_en = 1'b0;
        write_byte(8'h6D);
        exp_q.push_back(8'h6D); n_accepted++;
        repeat (2000) @(posedge clk);
        #1;
        check("gate_tx_low", tx, 0);
        check("gate_busy", busy, 1);
        check("gate_popped", empty, 1);
        tick_en = 1'b1;
        wait_idle("gate_drain", 2000);

        // Randomized traffic with flow control from the bench's own occupancy bound.
        for (int i = 0; i < 20; i++) begin
            repeat ($urandom_range(0, 300)) @(posedge clk);
            n = 0;
            while ((n_accepted - mon_started) >= DEPTH && n < 5000) begin
                @(posedge clk);
                n++;
            end
            if (n >= 5000) check("rand_room_timeout", n_accepted - mon_started, DEPTH - 1);
            b = 8'($urandom);
            write_byte(b);
            exp_q.push_back(b); n_accepted++;
        end
        wait_idle("rand_drain", 20000);
        check("final_full", full, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
